hex_display_scan: RTL
=====================

Name: hex_display_scan

Overview:
Parametrised successor to the single-digit seven-segment decoder. It drives NUM_DIGITS multiplexed hex digits from one shared segment bus. Features:
- a refresh divider and digit scan;
- double-buffered loading that commits only at frame boundaries, so the display never tears;
- per-digit blanking and decimal points;
- optional leading-zero suppression.

It sits between the datapath registers and the board's segment and anode pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
REFRESH_DIV, 50000, clock cycles each digit is held (>=2)
ACTIVE_LOW, 1, 1: segments and anodes are active-low; 0: active-high

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
Value  in  4*NUM_DIGITS  hex nibbles; digit i = Value[4i+3:4i], digit 0 is least significant
Dp  in  NUM_DIGITS  decimal point request per digit
Blank  in  NUM_DIGITS  force digit i dark
Load  in  1  capture Value/Dp/Blank into the pending buffer this cycle
Lz_Suppress  in  1  enable leading-zero suppression (level, sampled live)
Seg  out  8  {dp,g,f,e,d,c,b,a}, polarity per ACTIVE_LOW
An  out  NUM_DIGITS  digit enables, one-hot when a digit is lit, polarity per ACTIVE_LOW
Frame_Done  out  1  one-cycle pulse when a pending load is committed

Behaviour:
- One clock and one synchronous active-high reset (Clk, Reset). All outputs are registered.
- Reset state: div=0, idx=0, active and pending buffers all zero, pend_v=0. Seg=all off (8'hFF if ACTIVE_LOW). An=all off. Frame_Done=0.
- Divider: div increments every cycle. When div==REFRESH_DIV-1, div returns to 0 and tick=1.
- Scan index:
  - On tick, idx advances by 1; it wraps from NUM_DIGITS-1 to 0.
  - wrap = tick && idx==NUM_DIGITS-1.
- Load / commit rules:
  - Load=1, no wrap: pending <= inputs, pend_v <= 1. A later Load overwrites pending (last wins).
  - wrap with pend_v=1 and Load=0: active <= pending, pend_v <= 0, Frame_Done=1 next cycle.
  - wrap and Load=1 in the same cycle: the inputs bypass straight into active, pend_v <= 0, Frame_Done=1 next cycle.
  - wrap with pend_v=0 and Load=0: no commit, Frame_Done=0.
- Output pipeline:
  - Seg and An reflect the idx of the previous cycle (one-cycle latency from idx to pins).
  - The first digit appears on the cycle after Reset deasserts.
- Digit i is dark if any of the following holds:
  - active Blank[i]=1;
  - Lz_Suppress=1 and i is a leading zero: active nibbles i..NUM_DIGITS-1 are all 0 and i!=0.
- Dark digit: Seg all off and An all off, including the DP.
- Lit digit:
  - An has only bit idx asserted.
  - Seg[6:0] = hex glyph of the nibble: 0-9, A, b, C, d, E, F, same glyph set as the existing decoder.
  - Seg[7] = active Dp[idx].
- ACTIVE_LOW=0 inverts both Seg and An relative to the active-low encoding.
- Blank always overrides Dp. Digit 0 is never leading-zero suppressed, so a value of 0 shows "0".
- Reset mid-frame: returns to the reset state next cycle and discards pend_v. Frame_Done is never asserted out of reset.
- Elaboration: error if NUM_DIGITS<1, NUM_DIGITS>8, or REFRESH_DIV<2.

Decomposition:
- Package hex_display_pkg:
  - seg_t (logic [6:0]);
  - constant glyph table for 16 active-low glyphs;
  - SEG_OFF = 7'h7F;
  - function leading-zero mask (NUM_DIGITS-generic, takes the nibble vector).
- Sub-module hex_seg_decode: combinational nibble -> seg_t, built from the package table. Instantiated once on the muxed nibble.
- Top contains the divider, scan counter, pending/active buffers, commit logic, suppression logic and output registers.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1.
1. Reset held 3 cycles -> Seg=8'hFF, An=4'hF, Frame_Done=0. After release -> An=4'b1110, Seg=8'hC0 ("0"); An steps to 4'b1101 after 4 cycles; full frame every 16 cycles.
2. Load with Value=16'h12AF, Dp=0, mid-frame -> display is unchanged until the wrap. Frame_Done pulses once at the wrap. Next frame shows F,A,2,1 with Seg=8'h8E, 8'h88, 8'hA4, 8'hF9.
3. Two Loads in one frame (16'h1111, then 16'h2222) -> one Frame_Done; 16'h2222 is displayed. Load coinciding with the wrap cycle (16'h3333) -> committed immediately, Frame_Done next cycle.
4. Lz_Suppress=1 with Value=16'h0050 -> digits 3 and 2 dark (An=4'hF in their slots), digits 1 and 0 show "5","0". Value=16'h0000 -> only digit 0 lit, showing "0".
5. Blank=4'b0010 with Dp=4'b0011 -> digit 1 fully dark, no DP. Digit 0 Seg[7]=0 (DP lit).
6. Pending Load, then Reset asserted 1 cycle before the wrap -> no Frame_Done. Display is all zeros after reset. The pending value is never shown.

Source files
------------

// File: rtl/hex_display_pkg.sv
// Shared types, glyph table and leading-zero helper for the hex scan display.
package hex_display_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} glyphs, entry 15 first.
  localparam logic [15:0][6:0] GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [7:0] lz_mask(
    input logic [31:0] v,
    input int          n
  );
    logic [7:0] m;
    logic       nz;
    m  = '0;
    nz = 1'b0;
    for (int i = 7; i >= 1; i--) begin
      if (i < n) begin
        nz = nz | (v[4*i +: 4] != 4'h0);
        if (!nz) m[i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Nibble to active-low seven-segment glyph.
module hex_seg_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);

  assign seg = GLYPH[nib];

endmodule

// File: rtl/hex_display_scan.sv
// Multiplexed hex display: refresh divider, digit scan,
// frame-synchronous double buffer, blanking and zero suppression.
module hex_display_scan
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic [NUM_DIGITS-1:0]   Dp,
  input  logic [NUM_DIGITS-1:0]   Blank,
  input  logic                    Load,
  input  logic                    Lz_Suppress,
  output logic [7:0]              Seg,
  output logic [NUM_DIGITS-1:0]   An,
  output logic                    Frame_Done
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = $clog2(REFRESH_DIV);
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic INV = (ACTIVE_LOW == 0);

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || REFRESH_DIV < 2) begin : g_bad
      $error("hex_display_scan: illegal parameters");
    end
  endgenerate

  logic [DW-1:0]         div;
  logic [IW-1:0]         idx;
  logic [VW-1:0]         act_val, pend_val;
  logic [NUM_DIGITS-1:0] act_dp, pend_dp;
  logic [NUM_DIGITS-1:0] act_blank, pend_blank;
  logic                  pend_v;

  logic tick, wrap;
  assign tick = (div == DW'(REFRESH_DIV - 1));
  assign wrap = tick && (idx == IW'(NUM_DIGITS - 1));

  logic [7:0] lzm;
  assign lzm = lz_mask(32'(act_val), NUM_DIGITS);

  seg_t glyph;
  hex_seg_decode u_dec (
    .nib (act_val[4*idx +: 4]),
    .seg (glyph)
  );

  logic                  dark;
  logic [7:0]            seg_n;
  logic [NUM_DIGITS-1:0] an_n;

  // Active-low encoding; ACTIVE_LOW=0 flips it at the pins.
  always_comb begin
    dark  = act_blank[idx] | (Lz_Suppress & lzm[3'(idx)]);
    seg_n = {~act_dp[idx], glyph};
    an_n  = ~(NUM_DIGITS'(1) << idx);
    if (dark) begin
      seg_n = {1'b1, SEG_OFF};
      an_n  = '1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div        <= '0;
      idx        <= '0;
      act_val    <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_v     <= 1'b0;
      Frame_Done <= 1'b0;
      Seg        <= 8'hFF ^ {8{INV}};
      An         <= {NUM_DIGITS{~INV}};
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) idx <= wrap ? '0 : idx + 1'b1;

      Seg <= seg_n ^ {8{INV}};
      An  <= an_n ^ {NUM_DIGITS{INV}};

      if (wrap) begin
        // A load landing on the wrap skips the pending stage.
        if (Load) begin
          act_val   <= Value;
          act_dp    <= Dp;
          act_blank <= Blank;
        end else if (pend_v) begin
          act_val   <= pend_val;
          act_dp    <= pend_dp;
          act_blank <= pend_blank;
        end
        pend_v     <= 1'b0;
        Frame_Done <= Load | pend_v;
      end else begin
        Frame_Done <= 1'b0;
        if (Load) begin
          pend_val   <= Value;
          pend_dp    <= Dp;
          pend_blank <= Blank;
          pend_v     <= 1'b1;
        end
      end
    end
  end

endmodule
